ym3438_bus_master: RTL and testbench

YM3438_BUS_MASTER -- requirements
Module: ym3438_bus_master

---
 rtl/ym3438_bus_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ym3438_bus_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_bus_master.sv
// ym3438_bus_master
//   Turns one host register write (port, address, data) into the YM3438
//   two-phase bus cycle: an address write, an idle gap, a data write, then a
//   post-write wait. The wait is either fixed or a busy-flag poll.
//
// Build option:
//   YM3438_BUSY_POLL_EN - when defined, the post-write wait polls the busy
//   flag (bus_data_i[7]) through status reads, bounded by BUSY_WAIT cycles.
//   When undefined, the wait is a fixed BUSY_WAIT cycles and the read path
//   is inactive.
//
// Ports:
//   MCLK, IC                     clock, async active-low reset
//   req_valid/req_ready          host request handshake
//   req_port/req_addr/req_data   request fields, captured on acceptance
//   done                         one-cycle completion pulse
//   timeout                      sticky busy-poll expiry flag
//   bus_addr                     chip address pins {port, phase}
//   bus_data_o/bus_data_oe       chip write data and its drive enable
//   bus_data_i                   chip status read data
//   bus_cs_n/bus_wr_n/bus_rd_n   chip strobes, active-low
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | ready for a request
// A_SETUP  | address on bus, CS low, WR high
// A_STROBE | WR low for WR_PULSE cycles (address phase)
// A_HOLD   | WR high, address still held
// GAP      | CS high for ADDR_GAP cycles
// D_SETUP  | data on bus, CS low, WR high
// D_STROBE | WR low for WR_PULSE cycles (data phase)
// D_HOLD   | WR high, data still held
// BUSY     | post-write wait (fixed length, or one cycle before polling)
// P_READ   | status read, RD low for RD_PULSE cycles (poll build)
// P_REL    | strobes released between status reads (poll build)

module ym3438_bus_master #(
  parameter int WR_PULSE  = 2,
  parameter int ADDR_GAP  = 4,
  parameter int BUSY_WAIT = 32,
  parameter int RD_PULSE  = 2
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_port,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       timeout,
  output logic [1:0] bus_addr,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_i,
  output logic       bus_cs_n,
  output logic       bus_wr_n,
  output logic       bus_rd_n
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] A_SETUP  = 4'd1;
  localparam logic [3:0] A_STROBE = 4'd2;
  localparam logic [3:0] A_HOLD   = 4'd3;
  localparam logic [3:0] GAP      = 4'd4;
  localparam logic [3:0] D_SETUP  = 4'd5;
  localparam logic [3:0] D_STROBE = 4'd6;
  localparam logic [3:0] D_HOLD   = 4'd7;
  localparam logic [3:0] BUSY     = 4'd8;
`ifdef YM3438_BUSY_POLL_EN
  localparam logic [3:0] P_READ   = 4'd9;
  localparam logic [3:0] P_REL    = 4'd10;
`endif

  localparam int TW = 16;
  localparam int CW = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT + 1);

  // Timer reload values: the phase timer is a down-counter that exits its
  // state on the cycle it reads zero, so a state lasting N cycles loads N-1.
  localparam logic [TW-1:0] WR_LD  = TW'((WR_PULSE < 1) ? 0 : WR_PULSE - 1);
  localparam logic [TW-1:0] GAP_LD = TW'((ADDR_GAP < 1) ? 0 : ADDR_GAP - 1);
  localparam logic [TW-1:0] RD_LD  = TW'((RD_PULSE < 1) ? 0 : RD_PULSE - 1);
  localparam logic [CW-1:0] BW     = CW'(BUSY_WAIT);

  logic [3:0]    state, state_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [CW-1:0] busy_cnt, cnt_d, cnt_inc;
  logic          port_q;
  logic [7:0]    data_q;
  logic          fin;
  logic          accept;
  logic          wr_phase_d, strobe_d, rd_phase_d;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Busy-wait counter saturates so a long poll can never wrap past the limit.
  assign cnt_inc = (busy_cnt == BW) ? busy_cnt : busy_cnt + 1'b1;

`ifdef YM3438_BUSY_POLL_EN
  logic tmo_set;
  logic unused_in;
  assign unused_in = ^bus_data_i[6:0];
`else
  logic unused_in;
  assign unused_in = ^{bus_data_i, RD_LD};
`endif

  always_comb begin
    state_d = state;
    tmr_d   = (tmr != '0) ? tmr - 1'b1 : tmr;
    cnt_d   = busy_cnt;
    fin     = 1'b0;
`ifdef YM3438_BUSY_POLL_EN
    tmo_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d = A_SETUP;
          cnt_d   = '0;
        end
      end
      A_SETUP: begin
        state_d = A_STROBE;
        tmr_d   = WR_LD;
      end
      A_STROBE: if (tmr == '0) state_d = A_HOLD;
      A_HOLD: begin
        if (ADDR_GAP == 0) begin
          state_d = D_SETUP;
        end else begin
          state_d = GAP;
          tmr_d   = GAP_LD;
        end
      end
      GAP: if (tmr == '0) state_d = D_SETUP;
      D_SETUP: begin
        state_d = D_STROBE;
        tmr_d   = WR_LD;
      end
      D_STROBE: if (tmr == '0) state_d = D_HOLD;
      D_HOLD: begin
        cnt_d = '0;
        if (BUSY_WAIT == 0) begin
          state_d = IDLE;
          fin     = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
`ifdef YM3438_BUSY_POLL_EN
      BUSY: begin
        cnt_d   = cnt_inc;
        state_d = P_READ;
        tmr_d   = RD_LD;
      end
      P_READ: begin
        cnt_d = cnt_inc;
        if (tmr == '0) begin
          if (!bus_data_i[7]) begin
            state_d = IDLE;
            fin     = 1'b1;
          end else if (cnt_inc == BW) begin
            state_d = IDLE;
            fin     = 1'b1;
            tmo_set = 1'b1;
          end else begin
            state_d = P_REL;
          end
        end
      end
      P_REL: begin
        cnt_d = cnt_inc;
        if (cnt_inc == BW) begin
          state_d = IDLE;
          fin     = 1'b1;
          tmo_set = 1'b1;
        end else begin
          state_d = P_READ;
          tmr_d   = RD_LD;
        end
      end
`else
      BUSY: begin
        cnt_d = cnt_inc;
        if (cnt_inc == BW) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change cleanly on the
  // clock edge and fall back to their idle level the instant IC goes low.
  assign wr_phase_d = (state_d == A_SETUP) || (state_d == A_STROBE) ||
                      (state_d == A_HOLD)  || (state_d == D_SETUP)  ||
                      (state_d == D_STROBE) || (state_d == D_HOLD);
  assign strobe_d   = (state_d == A_STROBE) || (state_d == D_STROBE);
`ifdef YM3438_BUSY_POLL_EN
  assign rd_phase_d = (state_d == P_READ);
`else
  assign rd_phase_d = 1'b0;
`endif

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      state       <= IDLE;
      tmr         <= '0;
      busy_cnt    <= '0;
      port_q      <= 1'b0;
      data_q      <= 8'h00;
      done        <= 1'b0;
      bus_cs_n    <= 1'b1;
      bus_wr_n    <= 1'b1;
      bus_data_oe <= 1'b0;
      bus_addr    <= 2'b00;
      bus_data_o  <= 8'h00;
    end else begin
      state       <= state_d;
      tmr         <= tmr_d;
      busy_cnt    <= cnt_d;
      done        <= fin;
      bus_cs_n    <= ~(wr_phase_d | rd_phase_d);
      bus_wr_n    <= ~strobe_d;
      bus_data_oe <= wr_phase_d;
      // The address byte lives in bus_data_o from acceptance until D_SETUP,
      // so only port and data need their own capture registers.
      if (accept) begin
        port_q     <= req_port;
        data_q     <= req_data;
        bus_addr   <= {req_port, 1'b0};
        bus_data_o <= req_addr;
      end else if (state_d == D_SETUP) begin
        bus_addr   <= {port_q, 1'b1};
        bus_data_o <= data_q;
      end else if (rd_phase_d) begin
        bus_addr   <= 2'b00;
      end
    end
  end

`ifdef YM3438_BUSY_POLL_EN
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      bus_rd_n <= 1'b1;
      timeout  <= 1'b0;
    end else begin
      bus_rd_n <= ~rd_phase_d;
      if (tmo_set) timeout <= 1'b1;
    end
  end
`else
  assign bus_rd_n = 1'b1;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ym3438_bus_master.sv
// tb_ym3438_bus_master
//   Directed bench for ym3438_bus_master with default parameters. Each write
//   is compared cycle by cycle against a hand-built table of the expected bus
//   waveform; a bus monitor flags WR edges that coincide with address/data
//   changes and WR low outside a CS-low, RD-high window. Poll-build scenarios
//   are compiled in when YM3438_BUSY_POLL_EN is defined.

module tb_ym3438_bus_master;

  logic       MCLK = 1'b0;
  logic       IC = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_port = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic [7:0] bus_data_i;
  logic       req_ready, done, timeout;
  logic [1:0] bus_addr;
  logic [7:0] bus_data_o;
  logic       bus_data_oe, bus_cs_n, bus_wr_n, bus_rd_n;

  ym3438_bus_master dut (
    .MCLK(MCLK), .IC(IC),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_port(req_port), .req_addr(req_addr), .req_data(req_data),
    .done(done), .timeout(timeout),
    .bus_addr(bus_addr), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
    .bus_data_i(bus_data_i),
    .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n), .bus_rd_n(bus_rd_n)
  );

  always #5 MCLK = ~MCLK;

`ifdef YM3438_BUSY_POLL_EN
  localparam int TRACE_LAST = 12;
  localparam int EXP_DONE   = 16;
`else
  localparam int TRACE_LAST = 45;
  localparam int EXP_DONE   = 45;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and status-register model.
  logic       mon_en = 1'b0;
  logic       p_wr = 1'b1;
  logic       p_rd = 1'b1;
  logic [1:0] p_addr = 2'b00;
  logic [7:0] p_data = 8'h00;
  int         ovl_err = 0;
  int         rd_pulses = 0;
  int         rd_base = 0;
  int         busy_polls = 0;

  always @(negedge MCLK) begin
    if (mon_en) begin
      if (bus_wr_n !== p_wr && (bus_addr !== p_addr || bus_data_o !== p_data))
        ovl_err++;
      if (!bus_wr_n && (!bus_rd_n || bus_cs_n))
        ovl_err++;
    end
    if (p_rd && !bus_rd_n) rd_pulses++;
    p_wr   = bus_wr_n;
    p_rd   = bus_rd_n;
    p_addr = bus_addr;
    p_data = bus_data_o;
    bus_data_i = ((rd_pulses - rd_base) <= busy_polls) ? 8'h80 : 8'h00;
  end

  // Expected {cs_n, wr_n, rd_n, oe, addr[1:0], data[7:0], ready, done} for
  // cycle c after acceptance, default parameters, fixed-wait timing.
  function automatic logic [15:0] exp_vec(input int c, input logic p,
                                          input logic [7:0] a,
                                          input logic [7:0] d);
    logic       cs, wr, oe, rdy, dn;
    logic [1:0] ba;
    logic [7:0] bd;
    cs = 1'b1; wr = 1'b1; oe = 1'b0; rdy = 1'b0; dn = 1'b0;
    ba = 2'b00; bd = 8'h00;
    if (c >= 1 && c <= 4) begin
      cs = 1'b0; oe = 1'b1; ba = {p, 1'b0}; bd = a;
      wr = !(c == 2 || c == 3);
    end else if (c >= 9 && c <= 12) begin
      cs = 1'b0; oe = 1'b1; ba = {p, 1'b1}; bd = d;
      wr = !(c == 10 || c == 11);
    end
    if (c == 45) begin
      rdy = 1'b1; dn = 1'b1;
    end
    return {cs, wr, 1'b1, oe, ba, bd, rdy, dn};
  endfunction

  // Entered just before a rising edge with the DUT idle; returns at the
  // sampling point of the done cycle.
  task automatic run_write(input logic p, input logic [7:0] a,
                           input logic [7:0] d, input bit hold,
                           input logic np, input logic [7:0] na,
                           input logic [7:0] nd, output int dcyc);
    logic [15:0] e, g;
    req_port = p; req_addr = a; req_data = d; req_valid = 1'b1;
    @(posedge MCLK);
    #1;
    if (hold) begin
      req_port = np; req_addr = na; req_data = nd;
    end else begin
      req_valid = 1'b0;
    end
    dcyc = -1;
    for (int c = 1; c <= TRACE_LAST; c++) begin
      @(negedge MCLK);
      e = exp_vec(c, p, a, d);
      g = {bus_cs_n, bus_wr_n, bus_rd_n, bus_data_oe,
           e[12] ? bus_addr : 2'b00, e[12] ? bus_data_o : 8'h00,
           req_ready, done};
      check_val($sformatf("trace a%02h c%0d", a, c), {16'h0, g}, {16'h0, e});
      if (done) dcyc = c;
    end
`ifdef YM3438_BUSY_POLL_EN
    for (int c = TRACE_LAST + 1; c <= 300; c++) begin
      @(negedge MCLK);
      if (done) begin
        dcyc = c;
        break;
      end
    end
    if (dcyc < 0) check_val("done wait expired", 32'd0, 32'd1);
`endif
  endtask

  int dc;

  initial begin
    IC = 1'b0;
    repeat (3) @(negedge MCLK);
    check_val("rst strobes", {28'h0, bus_cs_n, bus_wr_n, bus_rd_n, bus_data_oe},
              32'b1110);
    check_val("rst bus", {22'h0, bus_addr, bus_data_o}, 32'h0);
    check_val("rst flags", {29'h0, req_ready, done, timeout}, 32'b100);

    @(posedge MCLK);
    #2 IC = 1'b1;
    mon_en = 1'b1;

    run_write(1'b0, 8'h28, 8'hF0, 1'b0, 1'b0, 8'h00, 8'h00, dc);
    check_val("done cyc 28", dc, EXP_DONE);
    run_write(1'b1, 8'hA4, 8'h22, 1'b0, 1'b0, 8'h00, 8'h00, dc);
    check_val("done cyc a4", dc, EXP_DONE);

    // Back-to-back with req_valid held; fields switch to the second request
    // while the first is in flight and must not disturb it.
    run_write(1'b0, 8'h30, 8'h5A, 1'b1, 1'b1, 8'hB4, 8'h1C, dc);
    check_val("done cyc b2b1", dc, EXP_DONE);
    run_write(1'b1, 8'hB4, 8'h1C, 1'b0, 1'b0, 8'h00, 8'h00, dc);
    check_val("done cyc b2b2", dc, EXP_DONE);
    check_val("bus overlap", ovl_err, 0);

    // Reset during D_STROBE.
    req_port = 1'b1; req_addr = 8'h55; req_data = 8'hAA; req_valid = 1'b1;
    @(posedge MCLK);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge MCLK);
    check_val("pre-rst dstrobe", {28'h0, bus_cs_n, bus_wr_n, bus_addr},
              32'b0011);
    mon_en = 1'b0;
    #2 IC = 1'b0;
    #1;
    check_val("rst async", {26'h0, bus_cs_n, bus_wr_n, bus_rd_n, bus_data_oe,
              req_ready, done}, 32'b111010);
    @(negedge MCLK);
    check_val("rst no done", {31'h0, done}, 32'd0);
    @(posedge MCLK);
    #2 IC = 1'b1;
    mon_en = 1'b1;
    run_write(1'b0, 8'h2B, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, dc);
    check_val("done cyc post-rst", dc, EXP_DONE);

`ifdef YM3438_BUSY_POLL_EN
    rd_base = rd_pulses; busy_polls = 3;
    run_write(1'b0, 8'h40, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, dc);
    check_val("poll3 done cyc", dc, 25);
    check_val("poll3 reads", rd_pulses - rd_base, 4);
    check_val("poll3 timeout", {31'h0, timeout}, 32'd0);

    rd_base = rd_pulses; busy_polls = 1000;
    run_write(1'b1, 8'h41, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, dc);
    check_val("stuck done cyc", dc, 46);
    check_val("stuck reads", rd_pulses - rd_base, 11);
    check_val("stuck timeout", {31'h0, timeout}, 32'd1);

    rd_base = rd_pulses; busy_polls = 0;
    run_write(1'b0, 8'h42, 8'h13, 1'b0, 1'b0, 8'h00, 8'h00, dc);
    check_val("after stuck done cyc", dc, 16);
    check_val("timeout sticky", {31'h0, timeout}, 32'd1);
`else
    check_val("fixed timeout", {31'h0, timeout}, 32'd0);
    check_val("fixed no reads", rd_pulses, 0);
`endif
    check_val("bus overlap end", ovl_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
